// File: rtl/balanca_aquisicao.sv
// Scale acquisition front-end: block averaging, tare, overload clamp and
// stability detection producing the net weight in grams.
module balanca_aquisicao #(
  parameter int RAW_W       = 16,
  parameter int AVG_LOG2    = 2,
  parameter int MAX_G       = 9999,
  parameter int STABLE_BAND = 2,
  parameter int STABLE_CNT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_valid,
  input  logic [RAW_W-1:0] raw_sample,
  input  logic             tare_req,
  output logic [13:0]      pesoemgramas,
  output logic             peso_valid,
  output logic             estavel,
  output logic             sobrecarga,
  output logic [13:0]      tara_g
);

  localparam int SUM_W = RAW_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int EXT_W = RAW_W + 1;
  localparam int SC_W  = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_ACUM,
    S_CALC,
    S_OUT
  } state_t;

  state_t           r_state;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [RAW_W-1:0] r_prev;
  logic [SC_W-1:0]  r_stab_cnt;
  logic             r_pend;
  logic             r_seen;
  logic [13:0]      r_tara;
  logic [13:0]      r_net_c;
  logic             r_ovl_c;
  logic [13:0]      r_peso;
  logic             r_pv;
  logic             r_est;
  logic             r_ovl;

  logic [RAW_W-1:0] w_avg;
  logic [EXT_W-1:0] w_avg_x;
  logic [EXT_W-1:0] w_tara_x;
  logic [EXT_W-1:0] w_maxg_x;
  logic [EXT_W-1:0] w_net_x;
  logic             w_net_ovl;
  logic [13:0]      w_tare_new;
  logic [RAW_W-1:0] w_diff;
  logic             w_stable;
  logic             w_last;

  always_comb begin
    w_avg      = r_sum[SUM_W-1:AVG_LOG2];
    w_avg_x    = {1'b0, w_avg};
    w_tara_x   = EXT_W'(r_tara);
    w_maxg_x   = EXT_W'(MAX_G);
    w_net_x    = '0;
    if (w_avg_x > w_tara_x)
      w_net_x  = w_avg_x - w_tara_x;
    w_net_ovl  = (w_net_x > w_maxg_x);
    w_tare_new = (w_avg_x > w_maxg_x) ? 14'(MAX_G)
                                      : w_avg[13:0];
    w_diff     = (w_avg >= r_prev) ? (w_avg - r_prev)
                                   : (r_prev - w_avg);
    w_stable   = (w_diff <= RAW_W'(STABLE_BAND));
    w_last     = (r_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_ACUM;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_stab_cnt <= '0;
      r_pend     <= 1'b0;
      r_seen     <= 1'b0;
      r_tara     <= '0;
      r_net_c    <= '0;
      r_ovl_c    <= 1'b0;
      r_peso     <= '0;
      r_pv       <= 1'b0;
      r_est      <= 1'b0;
      r_ovl      <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      unique case (r_state)
        S_ACUM: begin
          r_pend <= r_pend | tare_req;
          if (raw_valid) begin
            r_sum <= r_sum + SUM_W'(raw_sample);
            r_cnt <= r_cnt + 1'b1;
            if (w_last)
              r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // A request arriving now only arms the next block.
          r_pend <= tare_req;
          if (r_pend) begin
            r_tara  <= w_tare_new;
            r_net_c <= '0;
            r_ovl_c <= 1'b0;
          end else begin
            r_ovl_c <= w_net_ovl;
            r_net_c <= w_net_ovl ? 14'(MAX_G)
                                 : w_net_x[13:0];
          end
          if (!r_seen) begin
            r_seen <= 1'b1;
          end else if (w_stable) begin
            if (r_stab_cnt != SC_W'(STABLE_CNT))
              r_stab_cnt <= r_stab_cnt + 1'b1;
          end else begin
            r_stab_cnt <= '0;
          end
          r_prev  <= w_avg;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_pend  <= r_pend | tare_req;
          r_peso  <= r_net_c;
          r_ovl   <= r_ovl_c;
          r_est   <= (r_stab_cnt == SC_W'(STABLE_CNT));
          r_pv    <= 1'b1;
          r_sum   <= '0;
          r_cnt   <= '0;
          r_state <= S_ACUM;
        end
        default: r_state <= S_ACUM;
      endcase
    end
  end

  assign pesoemgramas = r_peso;
  assign peso_valid   = r_pv;
  assign estavel      = r_est;
  assign sobrecarga   = r_ovl;
  assign tara_g       = r_tara;

endmodule

// File: tb/tb_balanca_aquisicao.sv
// Self-checking bench for balanca_aquisicao: directed scenarios plus
// randomized blocks against a block-level reference model.
module tb_balanca_aquisicao;

  logic        clk;
  logic        rst;
  logic        raw_valid;
  logic [15:0] raw_sample;
  logic        tare_req;
  logic [13:0] pesoemgramas;
  logic        peso_valid;
  logic        estavel;
  logic        sobrecarga;
  logic [13:0] tara_g;

  int n_cmp;
  int n_bad;

  int m_tara, m_prev, m_cnt;
  bit m_pend, m_first;
  int e_peso, e_tara;
  bit e_ovl, e_est;

  balanca_aquisicao dut (
    .clk(clk), .rst(rst),
    .raw_valid(raw_valid), .raw_sample(raw_sample),
    .tare_req(tare_req),
    .pesoemgramas(pesoemgramas), .peso_valid(peso_valid),
    .estavel(estavel), .sobrecarga(sobrecarga),
    .tara_g(tara_g)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_tara = 0; m_prev = 0; m_cnt = 0;
    m_pend = 0; m_first = 1;
    e_peso = 0; e_tara = 0; e_ovl = 0; e_est = 0;
  endfunction

  function automatic void model_calc(input int avg);
    int net, d;
    if (m_pend) begin
      m_tara = (avg > 9999) ? 9999 : avg;
      net = 0;
      m_pend = 0;
    end else begin
      net = (avg <= m_tara) ? 0 : avg - m_tara;
    end
    e_ovl = (net > 9999);
    e_peso = e_ovl ? 9999 : net;
    d = (avg > m_prev) ? avg - m_prev : m_prev - avg;
    if (m_first) m_first = 0;
    else if (d <= 2) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
    else m_cnt = 0;
    m_prev = avg;
    e_est = (m_cnt == 8);
    e_tara = m_tara;
  endfunction

  task automatic drive_block(input int s[4], input int maxgap,
      output int lat, output logic [13:0] pg, output logic ov,
      output logic es, output logic [13:0] tg, output logic pv_next);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(0, maxgap);
      repeat (g) begin
        @(negedge clk);
        raw_valid = 0;
        raw_sample = 16'($urandom);
      end
      @(negedge clk);
      raw_valid = 1;
      raw_sample = 16'(s[i]);
    end
    @(posedge clk);
    @(negedge clk);
    raw_valid = 0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!peso_valid && lat < 10);
    pg = pesoemgramas; ov = sobrecarga;
    es = estavel; tg = tara_g;
    @(posedge clk);
    #1;
    pv_next = peso_valid;
  endtask

  task automatic pulse_tare();
    @(negedge clk);
    tare_req = 1;
    @(negedge clk);
    tare_req = 0;
    m_pend = 1;
  endtask

  task automatic test_reset();
    rst = 1; raw_valid = 0; raw_sample = 0; tare_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({pesoemgramas, peso_valid, estavel, sobrecarga, tara_g} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got peso=%0d pv=%b est=%b ovl=%b tara=%0d want all 0",
        pesoemgramas, peso_valid, estavel, sobrecarga, tara_g);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_blocks(input string nm, input int vals[], input int maxgap);
    int s[4];
    int lat;
    logic [13:0] pg, tg;
    logic ov, es, pvn;
    foreach (vals[b]) begin
      for (int i = 0; i < 4; i++) s[i] = vals[b] + ((b % 3 == 2) ? (i & 1) : 0);
      drive_block(s, maxgap, lat, pg, ov, es, tg, pvn);
      model_calc((s[0] + s[1] + s[2] + s[3]) / 4);
      n_cmp += 4;
      if (lat !== 2) begin
        n_bad++;
        $display("FAIL %s_latency blk%0d: got %0d want 2", nm, b, lat);
      end
      if (pvn !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_pulse_width blk%0d: got %b want 0", nm, b, pvn);
      end
      if (pg !== 14'(e_peso) || ov !== e_ovl) begin
        n_bad++;
        $display("FAIL %s_peso blk%0d: got %0d ovl=%b want %0d ovl=%b",
          nm, b, pg, ov, e_peso, e_ovl);
      end
      if (es !== e_est || tg !== 14'(e_tara)) begin
        n_bad++;
        $display("FAIL %s_est_tara blk%0d: got est=%b tara=%0d want est=%b tara=%0d",
          nm, b, es, tg, e_est, e_tara);
      end
    end
  endtask

  task automatic test_averaging();
    int s[4];
    int lat;
    logic [13:0] pg, tg;
    logic ov, es, pvn;
    s = '{1000, 1001, 1001, 1001};
    drive_block(s, 0, lat, pg, ov, es, tg, pvn);
    model_calc(1000);
    n_cmp += 2;
    if (lat !== 2 || pvn !== 1'b0) begin
      n_bad++;
      $display("FAIL avg_timing: got lat=%0d pv_next=%b want 2/0", lat, pvn);
    end
    if (pg !== 14'd1000 || ov !== 1'b0 || es !== 1'b0) begin
      n_bad++;
      $display("FAIL avg_value: got %0d ovl=%b est=%b want 1000/0/0", pg, ov, es);
    end
  endtask

  task automatic test_overload();
    test_blocks("ovl", '{12000, 5000}, 1);
  endtask

  task automatic test_tare();
    pulse_tare();
    test_blocks("tare", '{500, 1500, 200}, 1);
  endtask

  task automatic test_stability();
    test_blocks("stab", '{2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000}, 0);
    n_cmp++;
    if (estavel !== 1'b1) begin
      n_bad++;
      $display("FAIL stab_set: got %b want 1", estavel);
    end
    test_blocks("stab2", '{2003, 2004}, 0);
  endtask

  task automatic test_dropped();
    int vals[10];
    int exp_v;
    vals = '{100, 100, 100, 100, 999, 999, 104, 104, 104, 104};
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      raw_valid = (c <= 10);
      raw_sample = (c <= 10) ? 16'(vals[c-1]) : 16'd0;
      @(posedge clk);
      #1;
      if (c == 4) model_calc(100);
      if (c == 10) model_calc(104);
      exp_v = (c == 6 || c == 12) ? 1 : 0;
      n_cmp++;
      if (peso_valid !== exp_v[0]) begin
        n_bad++;
        $display("FAIL drop_pv cyc%0d: got %b want %0d", c, peso_valid, exp_v);
      end
      if (exp_v == 1) begin
        n_cmp++;
        if (pesoemgramas !== 14'(e_peso) || estavel !== e_est) begin
          n_bad++;
          $display("FAIL drop_peso cyc%0d: got %0d est=%b want %0d est=%b",
            c, pesoemgramas, estavel, e_peso, e_est);
        end
      end
    end
    raw_valid = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      raw_valid = 1;
      raw_sample = 16'd3000;
    end
    @(posedge clk);
    #2;
    rst = 1;
    raw_valid = 0;
    #1;
    n_cmp++;
    if ({pesoemgramas, peso_valid, estavel, sobrecarga, tara_g} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got peso=%0d pv=%b est=%b ovl=%b tara=%0d want all 0",
        pesoemgramas, peso_valid, estavel, sobrecarga, tara_g);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    test_blocks("rstmid", '{700}, 0);
  endtask

  task automatic test_random();
    int v[];
    for (int r = 0; r < 6; r++) begin
      v = new[4];
      foreach (v[k]) v[k] = (k > 0 && $urandom_range(0, 1) == 1)
          ? v[k-1] : int'($urandom_range(0, 14000));
      if ($urandom_range(0, 3) == 0) pulse_tare();
      test_blocks("rand", v, 3);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_averaging();
    test_overload();
    test_tare();
    test_stability();
    test_dropped();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
